param_issue_queue: RTL and testbench
====================================

Name: param_issue_queue

Overview:
Unified, parametrised out-of-order issue queue. It succeeds the fixed two-wide issue stage with configurable dispatch width, issue width, writeback-port count and depth. Each cycle it accepts renamed instructions from the rename stage and tracks operand readiness through writeback tag wakeup. It issues the oldest ready entries, ordered by active-list (AL) age, and squashes younger-than-branch entries on recall.

Parameters:
DEPTH, 16, number of queue entries (power of two, >= DISP_W)
DISP_W, 2, dispatch slots per cycle
ISSUE_W, 2, issue slots per cycle
WB_PORTS, 4, writeback/wakeup ports
AL_SIZE, 32, active-list size; AL_W = $clog2(AL_SIZE)
NUM_PREGS, 64, physical registers; TAG_W = $clog2(NUM_PREGS)
PAYLOAD_W, 64, opaque decoded-op payload carried to issue

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
ext_stall  in  1  downstream stall; freezes dispatch and issue
i_disp_valid  in  DISP_W  per-slot dispatch valid
i_disp_al_idx  in  DISP_W*AL_W  AL index per slot
i_disp_src_tag  in  DISP_W*2*TAG_W  two source physical tags per slot
i_disp_src_rdy  in  DISP_W*2  source already ready at rename
i_disp_payload  in  DISP_W*PAYLOAD_W  payload per slot
i_wb_valid  in  WB_PORTS  writeback valid
i_wb_tag  in  WB_PORTS*TAG_W  writeback destination tag
if_recall  in  1  recall/flush request
new_front  in  AL_W  first squashed AL index after recall
back  in  AL_W  oldest in-flight AL index (age origin)
o_iss_valid  out  ISSUE_W  issue valid, registered
o_iss_al_idx  out  ISSUE_W*AL_W  issued AL index
o_iss_payload  out  ISSUE_W*PAYLOAD_W  issued payload
o_free_cnt  out  $clog2(DEPTH+1)  free entries, registered
int_stall  out  1  rename must hold

Behaviour:
- Reset: all entries invalid, o_iss_valid=0, o_iss_* data=0, o_free_cnt=DEPTH, int_stall=0. Reset overrides recall, dispatch and wakeup in the same cycle.
- Entry state: valid, al_idx, tag[2], rdy[2], payload.
- Age: age(x) = (x - back) mod AL_SIZE, computed in AL_W bits. A smaller age is older.
- int_stall = (o_free_cnt < DISP_W) || ext_stall. The comparison is against the registered count, which is conservative for the current cycle.
- Dispatch happens when !int_stall && !if_recall. Valid slots, in slot order, are written into the lowest-indexed free entries at the clock edge. Invalid slots consume no entry.
- Dispatch/wakeup race: a dispatched src whose tag matches any i_wb_tag valid in the same cycle is written with rdy=1.
- Wakeup: each valid i_wb port sets rdy for every matching valid entry source at the edge. Multiple ports hitting the same tag are harmless. The woken entry is selectable the following cycle, so there is no same-cycle wb-to-issue bypass.
- Select:
  - Candidates are entries with valid && rdy[0] && rdy[1].
  - Up to ISSUE_W oldest candidates are picked by age.
  - Ties (impossible for legal AL use) are broken by the lower entry index.
  - Picked entries are invalidated and their data registered onto o_iss_* at the edge. Issue latency is 1 cycle from ready-at-entry to o_iss_valid.
  - Unused issue lanes drive valid=0. Lanes are filled oldest-first starting at lane 0.
- ext_stall=1: no dispatch, no select; o_iss_valid=0 next cycle. Wakeups are still applied.
- Recall (if_recall=1):
  - At the edge, every valid entry with age(al_idx) >= age(new_front) is invalidated.
  - Dispatch that cycle is dropped.
  - No select that cycle; o_iss_valid=0 next cycle.
  - Wakeups are still applied to survivors.
  - new_front == back squashes all entries.
- o_free_cnt is updated at the edge: DEPTH minus the post-update valid count.
- Full queue: int_stall holds rename off; select still drains. A simultaneous issue frees entries that become visible one cycle later.
- Empty queue: o_iss_valid=0 every cycle.
- AL wrap-around is handled purely by the modular age; the spec requires correct order across the AL_SIZE-1 to 0 boundary.
- A source tag equal to a tag already ready is the rename stage's responsibility (i_disp_src_rdy). The queue never clears rdy.

Test Plan:
- Reset, then dispatch 2 ready ops (al 3, 4; back=3) -> next cycle o_iss_valid=2'b11, lane0 al=3, lane1 al=4; o_free_cnt returns to 16.
- Dispatch op al=5 with src tag 9 not ready; i_wb tag=9 two cycles later -> o_iss_valid lane0 asserted exactly 1 cycle after the wb cycle, never earlier.
- Dispatch with src tag 12 while i_wb tag=12 in the same cycle -> issues next cycle (race covered).
- back=30, AL_SIZE=32, ready ops at al 31, 0, 1 dispatched out of order -> issue order 31, 0, then 1.
- Fill 15 waiting entries (DEPTH=16, DISP_W=2) -> int_stall=1; no slot is lost. One wakeup issue brings o_free_cnt to 2 -> int_stall deasserts.
- 8 waiting entries at al 3..10 with back=3; recall new_front=6 -> entries al 6..10 removed, o_free_cnt=13, o_iss_valid=0 that cycle. Later wakeups issue only al 3..5.

Source files
------------

// File: rtl/param_issue_queue.sv
// Parametrised out-of-order issue queue: dispatch, tag wakeup,
// oldest-first select by active-list age, and recall squash.
module param_issue_queue #(
    parameter int DEPTH      = 16,
    parameter int DISP_W     = 2,
    parameter int ISSUE_W    = 2,
    parameter int WB_PORTS   = 4,
    parameter int AL_SIZE    = 32,
    parameter int NUM_PREGS  = 64,
    parameter int PAYLOAD_W  = 64,
    localparam int AL_W      = $clog2(AL_SIZE),
    localparam int TAG_W     = $clog2(NUM_PREGS),
    localparam int CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           ext_stall,
    input  logic [DISP_W-1:0]              i_disp_valid,
    input  logic [DISP_W*AL_W-1:0]         i_disp_al_idx,
    input  logic [DISP_W*2*TAG_W-1:0]      i_disp_src_tag,
    input  logic [DISP_W*2-1:0]            i_disp_src_rdy,
    input  logic [DISP_W*PAYLOAD_W-1:0]    i_disp_payload,
    input  logic [WB_PORTS-1:0]            i_wb_valid,
    input  logic [WB_PORTS*TAG_W-1:0]      i_wb_tag,
    input  logic                           if_recall,
    input  logic [AL_W-1:0]                new_front,
    input  logic [AL_W-1:0]                back,
    output logic [ISSUE_W-1:0]             o_iss_valid,
    output logic [ISSUE_W*AL_W-1:0]        o_iss_al_idx,
    output logic [ISSUE_W*PAYLOAD_W-1:0]   o_iss_payload,
    output logic [CNT_W-1:0]               o_free_cnt,
    output logic                           int_stall
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] DISP_CNT = CNT_W'(DISP_W);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    logic [DEPTH-1:0]             valid_q, valid_d;
    logic [AL_W-1:0]              al_q [DEPTH];
    logic [AL_W-1:0]              al_d [DEPTH];
    logic [TAG_W-1:0]             tag_q [DEPTH][2];
    logic [TAG_W-1:0]             tag_d [DEPTH][2];
    logic [1:0]                   rdy_q [DEPTH];
    logic [1:0]                   rdy_d [DEPTH];
    logic [PAYLOAD_W-1:0]         payload_q [DEPTH];
    logic [PAYLOAD_W-1:0]         payload_d [DEPTH];
    logic [ISSUE_W-1:0]           iss_valid_q, iss_valid_d;
    logic [ISSUE_W*AL_W-1:0]      iss_al_q, iss_al_d;
    logic [ISSUE_W*PAYLOAD_W-1:0] iss_payload_q, iss_payload_d;
    logic [CNT_W-1:0]             free_cnt_q, free_cnt_d;

    logic             do_disp;
    logic             do_sel;
    logic [DEPTH-1:0] picked;
    logic [DEPTH-1:0] used;
    logic             found;
    logic [IDX_W-1:0] best_idx;
    logic [AL_W-1:0]  best_age;
    logic [AL_W-1:0]  front_age;
    logic [CNT_W-1:0] vcnt;
    logic [TAG_W-1:0] dtag;

    function automatic logic [AL_W-1:0] age_of(
        input logic [AL_W-1:0] x,
        input logic [AL_W-1:0] b
    );
        return x - b;
    endfunction

    function automatic logic wb_hit(
        input logic [TAG_W-1:0]          t,
        input logic [WB_PORTS-1:0]       v,
        input logic [WB_PORTS*TAG_W-1:0] tags
    );
        logic hit;
        hit = 1'b0;
        for (int p = 0; p < WB_PORTS; p++) begin
            if (v[p] && tags[p*TAG_W +: TAG_W] == t) hit = 1'b1;
        end
        return hit;
    endfunction

    assign int_stall = (free_cnt_q < DISP_CNT) || ext_stall;

    always_comb begin
        valid_d       = valid_q;
        al_d          = al_q;
        tag_d         = tag_q;
        rdy_d         = rdy_q;
        payload_d     = payload_q;
        iss_valid_d   = '0;
        iss_al_d      = '0;
        iss_payload_d = '0;
        picked        = '0;
        used          = '0;
        found         = 1'b0;
        best_idx      = '0;
        best_age      = '0;
        vcnt          = '0;
        dtag          = '0;
        front_age     = age_of(new_front, back);
        do_disp       = !int_stall && !if_recall;
        do_sel        = !ext_stall && !if_recall;

        for (int e = 0; e < DEPTH; e++) begin
            for (int s = 0; s < 2; s++) begin
                if (valid_q[e] && wb_hit(tag_q[e][s], i_wb_valid, i_wb_tag))
                    rdy_d[e][s] = 1'b1;
            end
        end

        // Each lane takes the oldest remaining candidate; strict < keeps lower index on ties
        if (do_sel) begin
            for (int l = 0; l < ISSUE_W; l++) begin
                found    = 1'b0;
                best_idx = '0;
                best_age = '0;
                for (int e = 0; e < DEPTH; e++) begin
                    if (valid_q[e] && rdy_q[e] == 2'b11 && !picked[e]) begin
                        if (!found || age_of(al_q[e], back) < best_age) begin
                            found    = 1'b1;
                            best_idx = IDX_W'(e);
                            best_age = age_of(al_q[e], back);
                        end
                    end
                end
                if (found) begin
                    picked[best_idx] = 1'b1;
                    iss_valid_d[l]   = 1'b1;
                    iss_al_d[l*AL_W +: AL_W] = al_q[best_idx];
                    iss_payload_d[l*PAYLOAD_W +: PAYLOAD_W] = payload_q[best_idx];
                end
            end
        end
        valid_d = valid_q & ~picked;

        if (if_recall) begin
            for (int e = 0; e < DEPTH; e++) begin
                if (valid_q[e] && age_of(al_q[e], back) >= front_age)
                    valid_d[e] = 1'b0;
            end
        end

        // Only entries free at the start of the cycle are reused
        if (do_disp) begin
            for (int s = 0; s < DISP_W; s++) begin
                if (i_disp_valid[s]) begin
                    found    = 1'b0;
                    best_idx = '0;
                    for (int e = 0; e < DEPTH; e++) begin
                        if (!found && !valid_q[e] && !used[e]) begin
                            found    = 1'b1;
                            best_idx = IDX_W'(e);
                        end
                    end
                    if (found) begin
                        used[best_idx]      = 1'b1;
                        valid_d[best_idx]   = 1'b1;
                        al_d[best_idx]      = i_disp_al_idx[s*AL_W +: AL_W];
                        payload_d[best_idx] = i_disp_payload[s*PAYLOAD_W +: PAYLOAD_W];
                        for (int k = 0; k < 2; k++) begin
                            dtag = i_disp_src_tag[(s*2+k)*TAG_W +: TAG_W];
                            tag_d[best_idx][k] = dtag;
                            rdy_d[best_idx][k] = i_disp_src_rdy[s*2+k]
                                | wb_hit(dtag, i_wb_valid, i_wb_tag);
                        end
                    end
                end
            end
        end

        for (int e = 0; e < DEPTH; e++) begin
            if (valid_d[e]) vcnt = vcnt + CNT_W'(1);
        end
        free_cnt_d = DEPTH_CNT - vcnt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q       <= '0;
            iss_valid_q   <= '0;
            iss_al_q      <= '0;
            iss_payload_q <= '0;
            free_cnt_q    <= DEPTH_CNT;
        end else begin
            valid_q       <= valid_d;
            iss_valid_q   <= iss_valid_d;
            iss_al_q      <= iss_al_d;
            iss_payload_q <= iss_payload_d;
            free_cnt_q    <= free_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        al_q      <= al_d;
        tag_q     <= tag_d;
        rdy_q     <= rdy_d;
        payload_q <= payload_d;
    end

    assign o_iss_valid   = iss_valid_q;
    assign o_iss_al_idx  = iss_al_q;
    assign o_iss_payload = iss_payload_q;
    assign o_free_cnt    = free_cnt_q;

endmodule

// File: tb/tb_param_issue_queue.sv
// Scoreboard bench for param_issue_queue: issue order, wakeup
// timing, full-queue stall, ext_stall and recall squash.
module tb_param_issue_queue;
    localparam int AL_W  = 5;
    localparam int TAG_W = 6;
    localparam int PW    = 64;

    logic          clk = 1'b0;
    logic          reset;
    logic          ext_stall;
    logic [1:0]    disp_valid;
    logic [9:0]    disp_al;
    logic [23:0]   disp_tag;
    logic [3:0]    disp_rdy;
    logic [127:0]  disp_pay;
    logic [3:0]    wb_valid;
    logic [23:0]   wb_tag;
    logic          recall;
    logic [4:0]    new_front;
    logic [4:0]    back;
    logic [1:0]    iss_valid;
    logic [9:0]    iss_al;
    logic [127:0]  iss_pay;
    logic [4:0]    free_cnt;
    logic          int_stall;

    int n_chk = 0;
    int n_err = 0;
    int sb[$];

    param_issue_queue dut (
        .clk           (clk),
        .reset         (reset),
        .ext_stall     (ext_stall),
        .i_disp_valid  (disp_valid),
        .i_disp_al_idx (disp_al),
        .i_disp_src_tag(disp_tag),
        .i_disp_src_rdy(disp_rdy),
        .i_disp_payload(disp_pay),
        .i_wb_valid    (wb_valid),
        .i_wb_tag      (wb_tag),
        .if_recall     (recall),
        .new_front     (new_front),
        .back          (back),
        .o_iss_valid   (iss_valid),
        .o_iss_al_idx  (iss_al),
        .o_iss_payload (iss_pay),
        .o_free_cnt    (free_cnt),
        .int_stall     (int_stall)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [63:0] pay(input int al);
        return 64'(al) * 64'h0001_0003_0005_0007 + 64'hBEEF;
    endfunction

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clr();
        disp_valid = '0;
        disp_al    = '0;
        disp_tag   = '0;
        disp_rdy   = '0;
        disp_pay   = '0;
        wb_valid   = '0;
        wb_tag     = '0;
        recall     = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        clr();
    endtask

    task automatic slot(input int s, input int al, input int t0,
                        input bit r0, input int t1, input bit r1);
        disp_valid[s] = 1'b1;
        disp_al[s*AL_W +: AL_W] = 5'(al);
        disp_tag[(s*2)*TAG_W +: TAG_W] = 6'(t0);
        disp_tag[(s*2+1)*TAG_W +: TAG_W] = 6'(t1);
        disp_rdy[s*2] = r0;
        disp_rdy[s*2+1] = r1;
        disp_pay[s*PW +: PW] = pay(al);
    endtask

    task automatic wb(input int p, input int t);
        wb_valid[p] = 1'b1;
        wb_tag[p*TAG_W +: TAG_W] = 6'(t);
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && sb.size() != 0; i++) step();
        check("drain_left", 64'(sb.size()), 64'd0);
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            for (int l = 0; l < 2; l++) begin
                if (iss_valid[l]) begin
                    if (sb.size() == 0) begin
                        check("iss_unexpected", 64'(iss_al[l*AL_W +: AL_W]), 64'h3F);
                    end else begin
                        int e;
                        e = sb.pop_front();
                        check("iss_al", 64'(iss_al[l*AL_W +: AL_W]), 64'(e));
                        check("iss_pay", iss_pay[l*PW +: PW], pay(e));
                    end
                end
            end
        end
    end

    initial begin
        clr();
        reset     = 1'b1;
        ext_stall = 1'b0;
        new_front = '0;
        back      = 5'd3;
        step();
        step();
        check("rst_valid", 64'(iss_valid), 64'd0);
        check("rst_al", 64'(iss_al), 64'd0);
        check("rst_pay", iss_pay[63:0] | iss_pay[127:64], 64'd0);
        check("rst_free", 64'(free_cnt), 64'd16);
        check("rst_stall", 64'(int_stall), 64'd0);
        reset = 1'b0;

        // two ready ops issue together, oldest on lane 0
        slot(0, 3, 1, 1, 2, 1);
        slot(1, 4, 3, 1, 4, 1);
        sb.push_back(3);
        sb.push_back(4);
        step();
        check("t1_free_disp", 64'(free_cnt), 64'd14);
        step();
        check("t1_valid", 64'(iss_valid), 64'b11);
        check("t1_free", 64'(free_cnt), 64'd16);

        // wakeup two cycles after dispatch; issue exactly one cycle after wb
        slot(0, 5, 9, 0, 7, 1);
        step();
        check("t2_a", 64'(iss_valid), 64'd0);
        step();
        check("t2_b", 64'(iss_valid), 64'd0);
        wb(2, 9);
        sb.push_back(5);
        step();
        check("t2_wbcyc", 64'(iss_valid), 64'd0);
        step();
        check("t2_issue", 64'(iss_valid), 64'b01);

        // dispatch and wakeup race in the same cycle
        slot(0, 6, 12, 0, 13, 1);
        wb(3, 12);
        sb.push_back(6);
        step();
        check("t3_a", 64'(iss_valid), 64'd0);
        step();
        check("t3_issue", 64'(iss_valid), 64'b01);

        // AL wrap: back=30, order 31, 0, 1
        back = 5'd30;
        slot(0, 1, 20, 0, 21, 1);
        slot(1, 0, 20, 0, 21, 1);
        step();
        slot(0, 31, 20, 0, 21, 1);
        step();
        wb(0, 20);
        sb.push_back(31);
        sb.push_back(0);
        sb.push_back(1);
        step();
        step();
        check("t4_first", 64'(iss_valid), 64'b11);
        step();
        check("t4_second", 64'(iss_valid), 64'b01);
        step();
        check("t4_free", 64'(free_cnt), 64'd16);

        // full queue: 15 waiting entries stall rename
        back = 5'd0;
        for (int k = 0; k < 7; k++) begin
            slot(0, 2*k, (k == 0) ? 31 : 30, 0, 1, 1);
            slot(1, 2*k+1, 30, 0, 1, 1);
            step();
        end
        check("t5_pre_stall", 64'(int_stall), 64'd0);
        slot(0, 14, 30, 0, 1, 1);
        step();
        check("t5_free_full", 64'(free_cnt), 64'd1);
        check("t5_stall", 64'(int_stall), 64'd1);
        wb(1, 31);
        sb.push_back(0);
        step();
        check("t5_wbcyc_stall", 64'(int_stall), 64'd1);
        step();
        check("t5_issue0", 64'(iss_valid), 64'b01);
        check("t5_free2", 64'(free_cnt), 64'd2);
        check("t5_unstall", 64'(int_stall), 64'd0);
        slot(0, 15, 30, 0, 1, 1);
        step();
        check("t5_free_again", 64'(free_cnt), 64'd1);
        for (int a = 1; a <= 15; a++) sb.push_back(a);
        wb(0, 30);
        step();
        drain(20);
        step();
        check("t5_free_end", 64'(free_cnt), 64'd16);

        // ext_stall holds off select, wakeups still land
        back = 5'd20;
        slot(0, 20, 1, 1, 2, 1);
        slot(1, 21, 44, 0, 2, 1);
        step();
        ext_stall = 1'b1;
        #1;
        check("t6_stall_comb", 64'(int_stall), 64'd1);
        wb(0, 44);
        step();
        check("t6_frozen", 64'(iss_valid), 64'd0);
        check("t6_free", 64'(free_cnt), 64'd14);
        ext_stall = 1'b0;
        sb.push_back(20);
        sb.push_back(21);
        step();
        check("t6_release", 64'(iss_valid), 64'b11);

        // recall squashes al 6..10 of 3..10
        back = 5'd3;
        for (int k = 0; k < 4; k++) begin
            slot(0, 3 + 2*k, 40, 0, 1, 1);
            slot(1, 4 + 2*k, 40, 0, 1, 1);
            step();
        end
        check("t7_free8", 64'(free_cnt), 64'd8);
        recall    = 1'b1;
        new_front = 5'd6;
        step();
        check("t7_free13", 64'(free_cnt), 64'd13);
        check("t7_noiss", 64'(iss_valid), 64'd0);
        wb(2, 40);
        sb.push_back(3);
        sb.push_back(4);
        sb.push_back(5);
        step();
        step();
        check("t7_iss_a", 64'(iss_valid), 64'b11);
        step();
        check("t7_iss_b", 64'(iss_valid), 64'b01);
        step();
        check("t7_iss_c", 64'(iss_valid), 64'd0);
        check("t7_free16", 64'(free_cnt), 64'd16);

        // new_front == back squashes everything; dispatch that cycle dropped
        back = 5'd10;
        slot(0, 10, 50, 0, 1, 1);
        slot(1, 11, 50, 0, 1, 1);
        step();
        check("t8_free14", 64'(free_cnt), 64'd14);
        recall    = 1'b1;
        new_front = 5'd10;
        slot(0, 12, 1, 1, 2, 1);
        slot(1, 13, 1, 1, 2, 1);
        step();
        check("t8_free16", 64'(free_cnt), 64'd16);
        wb(0, 50);
        step();
        check("t8_noiss_a", 64'(iss_valid), 64'd0);
        step();
        check("t8_noiss_b", 64'(iss_valid), 64'd0);
        step();
        check("t8_sb_empty", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
